// File: rtl/mem_stage_pkg.sv
// Shared constants and op encoding for the memory-access stage.
package mem_stage_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int MEM_DEPTH = 32;
    localparam int RD_W      = 3;

    // Execute-stage op encoding; 2'b11 is reserved and behaves as a pass.
    typedef enum logic [1:0] {
        OP_PASS  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

endpackage

// File: rtl/mem_access_stage_store_buffer.sv
// Single-entry posted-store buffer with address-match lookup for forwarding.
module store_buffer
    import mem_stage_pkg::*;
#(
    parameter int AW = mem_stage_pkg::ADDR_W,
    parameter int DW = mem_stage_pkg::DATA_W
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          drain_en,
    input  logic [AW-1:0] lookup_addr,
    output logic          valid,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          hit
);

    // A push always wins: the caller guarantees the old entry drains in the
    // same cycle, so overwriting it loses nothing.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (push) begin
            valid <= 1'b1;
            addr  <= push_addr;
            data  <= push_data;
        end else if (drain_en) begin
            valid <= 1'b0;
        end
    end

    // Forwarding match against the currently buffered entry.
    always_comb begin
        hit = valid && (addr == lookup_addr);
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: handshake, DMem port mux, posted stores, result register.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W    = mem_stage_pkg::DATA_W,
    parameter int ADDR_W    = mem_stage_pkg::ADDR_W,
    parameter int MEM_DEPTH = mem_stage_pkg::MEM_DEPTH,
    parameter int RD_W      = mem_stage_pkg::RD_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_regwrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] writeData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] readData,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_regwrite,
    output logic              addr_fault
);

    logic              fire;
    logic              is_load;
    logic              is_store;
    logic              in_rng;
    logic              load_fire;
    logic              push;
    logic              drain_en;
    logic              sb_valid;
    logic              sb_hit;
    logic [ADDR_W-1:0] sb_addr;
    logic [DATA_W-1:0] sb_data;
    logic [DATA_W-1:0] result;

    assign in_ready  = !wb_valid || wb_ready;
    assign fire      = in_valid && in_ready;
    assign is_load   = (in_op == OP_LOAD);
    assign is_store  = (in_op == OP_STORE);
    assign in_rng    = (in_addr < ADDR_W'(MEM_DEPTH));
    assign load_fire = fire && is_load && in_rng;
    assign push      = fire && is_store && in_rng;
    // A firing load owns the port; the buffered store waits for the next free cycle.
    assign drain_en  = sb_valid && !load_fire;

    store_buffer #(.AW(ADDR_W), .DW(DATA_W)) u_sb (
        .CLK         (CLK),
        .RST         (RST),
        .push        (push),
        .push_addr   (in_addr),
        .push_data   (in_wdata),
        .drain_en    (drain_en),
        .lookup_addr (in_addr),
        .valid       (sb_valid),
        .addr        (sb_addr),
        .data        (sb_data),
        .hit         (sb_hit)
    );

    // DMem port mux: load read, else store drain, else idle zeros.
    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = '0;
        writeData = '0;
        if (load_fire) begin
            MemRead = 1'b1;
            Address = in_addr;
        end else if (drain_en) begin
            MemWrite  = 1'b1;
            Address   = sb_addr;
            writeData = sb_data;
        end
    end

    // Result selection for the writeback register; forwarded data beats DMem.
    always_comb begin
        result = '0;
        if (is_load) begin
            if (!in_rng)     result = '0;
            else if (sb_hit) result = sb_data;
            else             result = readData;
        end else if (!is_store) begin
            result = in_alu;
        end
    end

    // Output register: load on fire, hold under backpressure, retire on ready.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_rd       <= '0;
            wb_regwrite <= 1'b0;
        end else if (fire) begin
            wb_valid    <= 1'b1;
            wb_data     <= result;
            wb_rd       <= in_rd;
            wb_regwrite <= in_regwrite && !is_store;
        end else if (wb_ready) begin
            wb_valid    <= 1'b0;
        end
    end

    // Sticky fault on any out-of-range load or store that fires.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            addr_fault <= 1'b0;
        else if (fire && (is_load || is_store) && !in_rng)
            addr_fault <= 1'b1;
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench: vector table for back-to-back traffic, hand sequences for stalls, faults, reset.
module tb_mem_access_stage;

    logic       CLK = 1'b0;
    logic       RST;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [7:0] in_addr;
    logic [7:0] in_wdata;
    logic [7:0] in_alu;
    logic [2:0] in_rd;
    logic       in_regwrite;
    logic [7:0] Address;
    logic [7:0] writeData;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] readData;
    logic       wb_valid;
    logic       wb_ready;
    logic [7:0] wb_data;
    logic [2:0] wb_rd;
    logic       wb_regwrite;
    logic       addr_fault;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:31];

    always #5 CLK = ~CLK;

    mem_access_stage dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_alu(in_alu),
        .in_rd(in_rd), .in_regwrite(in_regwrite),
        .Address(Address), .writeData(writeData),
        .MemRead(MemRead), .MemWrite(MemWrite), .readData(readData),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .addr_fault(addr_fault)
    );

    // Behavioural DMem: combinational read, write at the end of the cycle.
    assign readData = (Address < 8'd32) ? mem[Address[4:0]] : 8'h00;
    always @(posedge CLK) begin
        if (MemWrite && Address < 8'd32) mem[Address[4:0]] <= writeData;
    end

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] alu;
        logic [2:0] rd;
        logic       rw;
        logic [7:0] exp_data;
        logic       exp_rw;
        logic       exp_mr;
        logic       exp_mw;
        logic [7:0] exp_paddr;
        logic [7:0] exp_pwdata;
    } vec_t;

    vec_t vt [15];

    function automatic vec_t mk(logic [1:0] op, logic [7:0] addr, logic [7:0] wdata,
                                logic [7:0] alu, logic [2:0] rd, logic rw,
                                logic [7:0] ed, logic erw, logic emr, logic emw,
                                logic [7:0] epa, logic [7:0] epw);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.alu = alu; v.rd = rd; v.rw = rw;
        v.exp_data = ed; v.exp_rw = erw; v.exp_mr = emr; v.exp_mw = emw;
        v.exp_paddr = epa; v.exp_pwdata = epw;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] alu,
                         input logic [2:0] rd, input logic rw);
        in_valid = v; in_op = op; in_addr = addr; in_wdata = wdata;
        in_alu = alu; in_rd = rd; in_regwrite = rw;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);
        mem[17] = 8'hFF;

        //  op     addr   wdata  alu    rd rw  exp_d  erw mr mw paddr  pwdata
        vt[0]  = mk(2'b01, 8'd5,  8'h00, 8'h00, 1, 1, 8'h05, 1, 1, 0, 8'd5,  8'h00);
        vt[1]  = mk(2'b01, 8'd17, 8'h00, 8'h00, 2, 1, 8'hFF, 1, 1, 0, 8'd17, 8'h00);
        vt[2]  = mk(2'b00, 8'd0,  8'h00, 8'h3C, 3, 1, 8'h3C, 1, 0, 0, 8'd0,  8'h00);
        vt[3]  = mk(2'b10, 8'd3,  8'hA5, 8'h00, 4, 1, 8'h00, 0, 0, 0, 8'd0,  8'h00);
        vt[4]  = mk(2'b01, 8'd3,  8'h00, 8'h00, 5, 1, 8'hA5, 1, 1, 0, 8'd3,  8'h00);
        vt[5]  = mk(2'b00, 8'd0,  8'h00, 8'h77, 6, 1, 8'h77, 1, 0, 1, 8'd3,  8'hA5);
        vt[6]  = mk(2'b10, 8'd1,  8'h11, 8'h00, 7, 1, 8'h00, 0, 0, 0, 8'd0,  8'h00);
        vt[7]  = mk(2'b10, 8'd2,  8'h22, 8'h00, 0, 1, 8'h00, 0, 0, 1, 8'd1,  8'h11);
        vt[8]  = mk(2'b10, 8'd4,  8'h44, 8'h00, 1, 1, 8'h00, 0, 0, 1, 8'd2,  8'h22);
        vt[9]  = mk(2'b01, 8'd1,  8'h00, 8'h00, 2, 1, 8'h11, 1, 1, 0, 8'd1,  8'h00);
        vt[10] = mk(2'b01, 8'd2,  8'h00, 8'h00, 3, 1, 8'h22, 1, 1, 0, 8'd2,  8'h00);
        vt[11] = mk(2'b01, 8'd4,  8'h00, 8'h00, 4, 1, 8'h44, 1, 1, 0, 8'd4,  8'h00);
        vt[12] = mk(2'b00, 8'd0,  8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'd4,  8'h44);
        vt[13] = mk(2'b01, 8'd3,  8'h00, 8'h00, 3, 1, 8'hA5, 1, 1, 0, 8'd3,  8'h00);
        vt[14] = mk(2'b11, 8'd0,  8'h00, 8'h5A, 4, 1, 8'h5A, 1, 0, 0, 8'd0,  8'h00);

        // Reset state
        RST = 1'b1; wb_ready = 1'b1;
        drive(0, 2'b00, 8'd0, 8'h00, 8'h00, 0, 0);
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_data", 32'(wb_data), 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_wb_regwrite", 32'(wb_regwrite), 0);
        chk("rst_addr_fault", 32'(addr_fault), 0);
        chk("rst_memread", 32'(MemRead), 0);
        chk("rst_memwrite", 32'(MemWrite), 0);
        chk("rst_address", 32'(Address), 0);
        tick(); tick();
        RST = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready), 1);

        // Back-to-back vector table, wb_ready held high
        for (int i = 0; i < 15; i++) begin
            drive(1, vt[i].op, vt[i].addr, vt[i].wdata, vt[i].alu, vt[i].rd, vt[i].rw);
            #1;
            chk($sformatf("v%0d_memread", i), 32'(MemRead), 32'(vt[i].exp_mr));
            chk($sformatf("v%0d_memwrite", i), 32'(MemWrite), 32'(vt[i].exp_mw));
            chk($sformatf("v%0d_address", i), 32'(Address), 32'(vt[i].exp_paddr));
            chk($sformatf("v%0d_writedata", i), 32'(writeData), 32'(vt[i].exp_pwdata));
            @(posedge CLK); #1;
            chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 1);
            if (vt[i].op != 2'b10)
                chk($sformatf("v%0d_wb_data", i), 32'(wb_data), 32'(vt[i].exp_data));
            chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(vt[i].rd));
            chk($sformatf("v%0d_wb_regwrite", i), 32'(wb_regwrite), 32'(vt[i].exp_rw));
        end
        chk("no_fault_yet", 32'(addr_fault), 0);

        // Writeback stall with a buffered store draining underneath
        drive(1, 2'b10, 8'd6, 8'h66, 8'h00, 0, 1);
        tick();
        drive(1, 2'b01, 8'd7, 8'h00, 8'h00, 5, 1);
        #1;
        chk("stl_load_memread", 32'(MemRead), 1);
        chk("stl_load_defers_drain", 32'(MemWrite), 0);
        @(posedge CLK); #1;
        chk("stl_load_data", 32'(wb_data), 8'h07);
        wb_ready = 1'b0;
        drive(1, 2'b01, 8'd8, 8'h00, 8'h00, 6, 1);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stl%0d_in_ready", c), 32'(in_ready), 0);
            chk($sformatf("stl%0d_memread", c), 32'(MemRead), 0);
            chk($sformatf("stl%0d_memwrite", c), 32'(MemWrite), (c == 0) ? 1 : 0);
            if (c == 0) begin
                chk("stl_drain_addr", 32'(Address), 6);
                chk("stl_drain_wdata", 32'(writeData), 8'h66);
            end
            @(posedge CLK); #1;
            chk($sformatf("stl%0d_wb_valid", c), 32'(wb_valid), 1);
            chk($sformatf("stl%0d_wb_data", c), 32'(wb_data), 8'h07);
            chk($sformatf("stl%0d_wb_rd", c), 32'(wb_rd), 5);
        end
        wb_ready = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 1);
        chk("rel_memread", 32'(MemRead), 1);
        chk("rel_address", 32'(Address), 8);
        @(posedge CLK); #1;
        chk("rel_wb_data", 32'(wb_data), 8'h08);
        chk("rel_wb_rd", 32'(wb_rd), 6);
        drive(1, 2'b01, 8'd6, 8'h00, 8'h00, 1, 1);
        tick();
        chk("stl_drained_value", 32'(wb_data), 8'h66);

        // Out-of-range accesses
        drive(1, 2'b01, 8'd40, 8'h00, 8'h00, 1, 1);
        #1;
        chk("flt_no_memread", 32'(MemRead), 0);
        chk("flt_address", 32'(Address), 0);
        @(posedge CLK); #1;
        chk("flt_wb_valid", 32'(wb_valid), 1);
        chk("flt_wb_data", 32'(wb_data), 0);
        chk("flt_addr_fault", 32'(addr_fault), 1);
        drive(1, 2'b10, 8'd50, 8'hAB, 8'h00, 2, 1);
        tick();
        chk("flt_store_wb_valid", 32'(wb_valid), 1);
        chk("flt_store_wb_regwrite", 32'(wb_regwrite), 0);
        drive(1, 2'b00, 8'd0, 8'h00, 8'h12, 3, 1);
        #1;
        chk("flt_store_discarded", 32'(MemWrite), 0);
        @(posedge CLK); #1;
        chk("flt_pass_data", 32'(wb_data), 8'h12);
        chk("flt_sticky1", 32'(addr_fault), 1);
        drive(1, 2'b01, 8'd5, 8'h00, 8'h00, 4, 1);
        tick();
        chk("flt_legal_load", 32'(wb_data), 8'h05);
        chk("flt_sticky2", 32'(addr_fault), 1);

        // Reset with a buffered store pending
        drive(1, 2'b10, 8'd9, 8'h99, 8'h00, 0, 1);
        tick();
        drive(0, 2'b00, 8'd0, 8'h00, 8'h00, 0, 0);
        #1;
        chk("pre_rst_drain_pending", 32'(MemWrite), 1);
        RST = 1'b1;
        #1;
        chk("mid_rst_memwrite", 32'(MemWrite), 0);
        chk("mid_rst_address", 32'(Address), 0);
        chk("mid_rst_wb_valid", 32'(wb_valid), 0);
        chk("mid_rst_wb_data", 32'(wb_data), 0);
        chk("mid_rst_addr_fault", 32'(addr_fault), 0);
        tick();
        RST = 1'b0;
        tick();
        chk("post_rst_memwrite", 32'(MemWrite), 0);
        chk("post_rst_mem9", 32'(mem[9]), 8'h09);
        drive(1, 2'b01, 8'd9, 8'h00, 8'h00, 2, 1);
        tick();
        chk("post_rst_load9", 32'(wb_data), 8'h09);
        drive(0, 2'b00, 8'd0, 8'h00, 8'h00, 0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
